// File: rtl/cic_comp_fir_if.sv
// cic_comp_fir_if: ready/valid sample streams in and out of the
// CIC compensation FIR.
interface cic_comp_fir_if #(
  parameter int IN_WIDTH  = 24,
  parameter int OUT_WIDTH = 24
);

  logic                        in_valid;
  logic                        in_ready;
  logic signed [IN_WIDTH-1:0]  in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [OUT_WIDTH-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/cic_comp_fir.sv
// cic_comp_fir: symmetric FIR droop compensation behind a CIC decimator.
// Optional sticky saturation flag port: define CIC_COMP_FIR_SAT_FLAG_EN.
module cic_comp_fir #(
  parameter int TAPS       = 21,
  parameter int IN_WIDTH   = 24,
  parameter int OUT_WIDTH  = 24,
  parameter int COEF_WIDTH = 18,
  parameter int COEF_FRAC  = 17,
  parameter logic signed [COEF_WIDTH-1:0] COEFS [(TAPS+1)/2] = '{
    -18'sd393,   18'sd655,   -18'sd1180,  18'sd1966,
    -18'sd3277,  18'sd5243,  -18'sd8389,  18'sd13107,
    -18'sd19661, 18'sd26214, 18'sd110000
  }
) (
  input  logic          in_clock,
  input  logic          in_reset_n,
`ifdef CIC_COMP_FIR_SAT_FLAG_EN
  output logic          sat_flag,
`endif
  cic_comp_fir_if.slave bus
);

  localparam int HALF   = (TAPS + 1) / 2;
  localparam int ACC_W  = IN_WIDTH + 1 + COEF_WIDTH + $clog2(HALF);
  localparam int RW     = ACC_W + 1;
  localparam int PW     = $clog2(TAPS);
  localparam int KW     = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int PRE_W  = IN_WIDTH + 1;
  localparam int PROD_W = PRE_W + COEF_WIDTH;

  localparam logic [PW-1:0] LAST  = PW'(TAPS - 1);
  localparam logic [KW-1:0] KLAST = KW'(HALF - 1);

  localparam logic signed [RW-1:0] RHALF =
    RW'(1) << (COEF_FRAC - 1);
  localparam logic signed [RW-1:0] SMAX =
    {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] SMIN =
    {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  if (TAPS < 3 || (TAPS % 2) == 0) begin : g_bad_taps
    $error("cic_comp_fir: TAPS must be odd and >= 3");
  end
  if (OUT_WIDTH < 2 || OUT_WIDTH > ACC_W) begin : g_bad_out
    $error("cic_comp_fir: OUT_WIDTH out of range");
  end
  if (COEF_FRAC >= ACC_W || COEF_FRAC < 1) begin : g_bad_frac
    $error("cic_comp_fir: COEF_FRAC out of range");
  end

  logic [1:0]                  state_q, state_d;
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]               ptr_a_q, ptr_a_d;
  logic [PW-1:0]               ptr_b_q, ptr_b_d;
  logic [KW-1:0]               k_q, k_d;
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic signed [IN_WIDTH-1:0]  hist_q [TAPS];
  logic signed [IN_WIDTH-1:0]  hist_d [TAPS];
  logic                        out_valid_q, out_valid_d;
  logic signed [OUT_WIDTH-1:0] out_data_q, out_data_d;

  logic signed [PRE_W-1:0]     pre;
  logic signed [PROD_W-1:0]    prod;
  logic signed [RW-1:0]        rnd;
  logic signed [RW-1:0]        shifted;
  logic signed [OUT_WIDTH-1:0] res;
  logic                        clip_hi;
  logic                        clip_lo;
  logic                        slot_free;
  logic                        load;

  // Pre-add the mirrored pair (centre tap alone) and weight it.
  always_comb begin
    pre = PRE_W'(hist_q[ptr_a_q]);
    if (k_q != KLAST) begin
      pre = PRE_W'(hist_q[ptr_a_q]) + PRE_W'(hist_q[ptr_b_q]);
    end
    prod = PROD_W'(COEFS[k_q]) * PROD_W'(pre);
  end

  // Round half up, then clip into the output range.
  always_comb begin
    rnd     = RW'(acc_q) + RHALF;
    shifted = rnd >>> COEF_FRAC;
    clip_hi = shifted > SMAX;
    clip_lo = shifted < SMIN;
    res     = shifted[OUT_WIDTH-1:0];
    if (clip_hi) begin
      res = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else if (clip_lo) begin
      res = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end
  end

  assign slot_free = !out_valid_q || bus.out_ready;

  // Sequencer: accept, walk the pointer pairs through HALF MACs, hold.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    ptr_a_d  = ptr_a_q;
    ptr_b_d  = ptr_b_q;
    k_d      = k_q;
    acc_d    = acc_q;
    hist_d   = hist_q;
    load     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          hist_d[wr_ptr_q] = bus.in_data;
          ptr_a_d  = wr_ptr_q;
          ptr_b_d  = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
          wr_ptr_d = ptr_b_d;
          acc_d    = '0;
          k_d      = '0;
          state_d  = S_MAC;
        end
      end
      S_MAC: begin
        acc_d   = acc_q + ACC_W'(prod);
        k_d     = k_q + KW'(1);
        ptr_a_d = (ptr_a_q == '0) ? LAST : ptr_a_q - PW'(1);
        ptr_b_d = (ptr_b_q == LAST) ? '0 : ptr_b_q + PW'(1);
        if (k_q == KLAST) begin
          k_d     = '0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (slot_free) begin
          load    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output slot: held until consumed, refilled in the same cycle.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = res;
    end
  end

  // State, history and output registers.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      ptr_a_q     <= '0;
      ptr_b_q     <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < TAPS; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      ptr_a_q     <= ptr_a_d;
      ptr_b_q     <= ptr_b_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      hist_q      <= hist_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

`ifdef CIC_COMP_FIR_SAT_FLAG_EN
  logic sat_q, sat_d;

  // Sticky: set by the first clipped result reaching the output.
  always_comb begin
    sat_d = sat_q | (load & (clip_hi | clip_lo));
  end

  // Flag register, cleared only by reset.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat_flag = sat_q;
`endif

endmodule
